geofence_feeder: RTL and testbench

//  Upstream stage of the geofence core. Gathers 7-point frames from a valid/ready point stream:
//  - point 0: object
//  - points 1..6: fence vertices

---
 rtl/geofence_pkg.sv | 39 +++
 rtl/geofence_feeder_if.sv | 32 +++
 rtl/geofence_frame_buf.sv | 107 ++++++++++
 rtl/geofence_feeder.sv | 182 ++++++++++++++++++
 tb/tb_geofence_feeder.sv | 321 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/geofence_pkg.sv
// geofence_pkg: types and constants shared by the geofence feeder slice.
//   COORD_W        coordinate width
//   FRAME_PTS      points per frame (object + six fence vertices)
//   GF_RUN_CYCLES  length of one nominal core run in cycles
//   point_t        one {x, y} point
//   feeder_state_t read-side FSM states
package geofence_pkg;

    localparam int COORD_W       = 10;
    localparam int FRAME_PTS     = 7;
    localparam int GF_RUN_CYCLES = 26;

    // Index of the last fence vertex inside a frame.
    localparam logic [2:0] LAST_IDX = 3'd6;

    typedef struct packed {
        logic [COORD_W-1:0] x;
        logic [COORD_W-1:0] y;
    } point_t;

    typedef enum logic [1:0] {
        OBJ   = 2'd0,
        FENCE = 2'd1,
        PAD   = 2'd2,
        WAIT  = 2'd3
    } feeder_state_t;

    // Dummy runs must present all-zero coordinates to the core.
    function automatic point_t point_or_zero(input logic en, input point_t p);
        point_t r;
        if (en) begin
            r = p;
        end else begin
            r = '0;
        end
        return r;
    endfunction

endpackage

// File: rtl/geofence_feeder_if.sv
// geofence_feeder_if: valid/ready point stream into the geofence feeder.
//   in_valid  upstream point valid
//   in_ready  feeder can accept a point
//   in_sop    point is frame point 0 (the object)
//   in_x/in_y point coordinates
// master = upstream point source, slave = feeder.
interface geofence_feeder_if;
    import geofence_pkg::*;

    logic               in_valid;
    logic               in_ready;
    logic               in_sop;
    logic [COORD_W-1:0] in_x;
    logic [COORD_W-1:0] in_y;

    modport master (
        output in_valid,
        output in_sop,
        output in_x,
        output in_y,
        input  in_ready
    );

    modport slave (
        input  in_valid,
        input  in_sop,
        input  in_x,
        input  in_y,
        output in_ready
    );

endinterface

// File: rtl/geofence_frame_buf.sv
// geofence_frame_buf: two 7-point frame slots with full flags, write pointer
// and start-of-packet checking.
//   clk, reset           clock, asynchronous active-high reset
//   wr_valid/wr_sop/wr_point/wr_ready   incoming point handshake
//   free_valid/free_slot release a slot once its result is consumed
//   rd_slot/rd_idx       read address, rd_point is the stored point
//   rd_full              full flag of rd_slot
//   err_seq              sticky flag for a broken sop sequence
module geofence_frame_buf
    import geofence_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       wr_valid,
    input  logic       wr_sop,
    input  point_t     wr_point,
    output logic       wr_ready,
    input  logic       free_valid,
    input  logic       free_slot,
    input  logic       rd_slot,
    input  logic [2:0] rd_idx,
    output point_t     rd_point,
    output logic       rd_full,
    output logic       err_seq
);

    point_t     slot_r [0:1][0:FRAME_PTS-1];
    logic [1:0] full_r;
    logic       wr_slot_r;
    logic [2:0] wr_idx_r;
    logic       err_seq_r;

    logic       accept_s;
    logic       drop_s;
    logic       restart_s;
    logic       store_s;
    logic       done_s;
    logic [2:0] wr_pos_s;
    logic [2:0] wr_idx_s;

    // Ready depends on registered state only, never on wr_valid.
    assign wr_ready = ~full_r[wr_slot_r];
    assign rd_full  = full_r[rd_slot];
    assign err_seq  = err_seq_r;

    // Classify an accepted point: drop, restart the frame, or store in place.
    always_comb begin
        accept_s  = wr_valid & wr_ready;
        drop_s    = 1'b0;
        restart_s = 1'b0;
        if (accept_s && !wr_sop && (wr_idx_r == 3'd0)) begin
            drop_s = 1'b1;
        end else if (accept_s && wr_sop && (wr_idx_r != 3'd0)) begin
            restart_s = 1'b1;
        end else begin
            drop_s    = 1'b0;
            restart_s = 1'b0;
        end
        store_s  = accept_s & ~drop_s;
        // A misplaced sop throws the partial frame away and starts over at 0.
        wr_pos_s = restart_s ? 3'd0 : wr_idx_r;
        done_s   = store_s & (wr_pos_s == LAST_IDX);
        wr_idx_s = done_s ? 3'd0 : (wr_pos_s + 3'd1);
    end

    // Read port mux; indices past the frame read as zero.
    always_comb begin
        if (rd_idx <= LAST_IDX) begin
            rd_point = slot_r[rd_slot][rd_idx];
        end else begin
            rd_point = '0;
        end
    end

    // Slot storage, full flags, write pointer and sequence error.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int s = 0; s < 2; s++) begin
                for (int p = 0; p < FRAME_PTS; p++) begin
                    slot_r[s][p] <= '0;
                end
            end
            full_r    <= 2'b00;
            wr_slot_r <= 1'b0;
            wr_idx_r  <= 3'd0;
            err_seq_r <= 1'b0;
        end else begin
            if (store_s) begin
                slot_r[wr_slot_r][wr_pos_s] <= wr_point;
                wr_idx_r                    <= wr_idx_s;
            end
            // The freed slot is always the other one when a write completes,
            // so both updates can land in the same cycle.
            if (free_valid) begin
                full_r[free_slot] <= 1'b0;
            end
            if (done_s) begin
                full_r[wr_slot_r] <= 1'b1;
                wr_slot_r         <= ~wr_slot_r;
            end
            if (drop_s || restart_s) begin
                err_seq_r <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/geofence_feeder.sv
// geofence_feeder: gathers 7-point frames from a valid/ready stream and
// replays them to the geofence core at its fixed, non-stallable cadence
// (object cycle, six fence cycles, pad, then wait for the result).
//   clk, reset        clock, asynchronous active-high reset
//   in_if             point stream (slave side)
//   X, Y              coordinates presented to the core
//   gf_valid/gf_inside core result pulse and verdict
//   res_valid/res_inside/res_tag  result of a live frame, one cycle after gf_valid
//   err_seq           sticky: bad sop sequence seen
//   err_timeout       sticky: core result never arrived during WAIT
module geofence_feeder
    import geofence_pkg::*;
#(
    parameter int TIMEOUT = 40,
    parameter int TAG_W   = 8
) (
    input  logic               clk,
    input  logic               reset,
    geofence_feeder_if.slave   in_if,
    output logic [COORD_W-1:0] X,
    output logic [COORD_W-1:0] Y,
    input  logic               gf_valid,
    input  logic               gf_inside,
    output logic               res_valid,
    output logic               res_inside,
    output logic [TAG_W-1:0]   res_tag,
    output logic               err_seq,
    output logic               err_timeout
);

    localparam int                WCNT_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [WCNT_W-1:0] WCNT_LAST = WCNT_W'(TIMEOUT - 1);
    localparam logic [WCNT_W-1:0] WCNT_ONE  = WCNT_W'(1);
    localparam logic [TAG_W-1:0]  TAG_ONE   = TAG_W'(1);

    feeder_state_t     state_r;
    feeder_state_t     state_s;
    logic [2:0]        idx_r;
    logic [2:0]        idx_s;
    logic              live_r;
    logic              live_s;
    logic [WCNT_W-1:0] wcnt_r;
    logic [WCNT_W-1:0] wcnt_s;
    logic              rd_slot_r;
    logic [TAG_W-1:0]  rd_tag_r;
    logic              res_valid_r;
    logic              res_inside_r;
    logic [TAG_W-1:0]  res_tag_r;
    logic              err_timeout_r;

    logic [2:0]        rd_idx_s;
    logic              feed_s;
    logic              done_s;
    logic              timeout_s;
    logic              free_s;
    logic              wr_ready_s;
    logic              rd_full_s;
    point_t            wr_point_s;
    point_t            rd_point_s;
    point_t            feed_point_s;

    assign wr_point_s     = {in_if.in_x, in_if.in_y};
    assign in_if.in_ready = wr_ready_s;
    // A slot is only released by a result that belongs to a real frame.
    assign free_s         = done_s & live_r;

    assign res_valid   = res_valid_r;
    assign res_inside  = res_inside_r;
    assign res_tag     = res_tag_r;
    assign err_timeout = err_timeout_r;

    geofence_frame_buf u_buf (
        .clk        (clk),
        .reset      (reset),
        .wr_valid   (in_if.in_valid),
        .wr_sop     (in_if.in_sop),
        .wr_point   (wr_point_s),
        .wr_ready   (wr_ready_s),
        .free_valid (free_s),
        .free_slot  (rd_slot_r),
        .rd_slot    (rd_slot_r),
        .rd_idx     (rd_idx_s),
        .rd_point   (rd_point_s),
        .rd_full    (rd_full_s),
        .err_seq    (err_seq)
    );

    // Read FSM next state plus the read address and feed enable for X/Y.
    always_comb begin
        state_s   = state_r;
        idx_s     = idx_r;
        live_s    = live_r;
        wcnt_s    = wcnt_r;
        rd_idx_s  = 3'd0;
        feed_s    = 1'b0;
        done_s    = 1'b0;
        timeout_s = 1'b0;
        case (state_r)
            OBJ: begin
                // The run is live only if a complete frame is waiting now.
                live_s  = rd_full_s;
                feed_s  = rd_full_s;
                idx_s   = 3'd1;
                state_s = FENCE;
            end
            FENCE: begin
                rd_idx_s = idx_r;
                feed_s   = live_r;
                if (idx_r == LAST_IDX) begin
                    state_s = PAD;
                end else begin
                    idx_s = idx_r + 3'd1;
                end
            end
            PAD: begin
                wcnt_s  = '0;
                state_s = WAIT;
            end
            WAIT: begin
                if (gf_valid) begin
                    done_s  = 1'b1;
                    state_s = OBJ;
                end else if (wcnt_r == WCNT_LAST) begin
                    // Resync; the slot stays full so a live frame is fed again.
                    timeout_s = 1'b1;
                    state_s   = OBJ;
                end else begin
                    wcnt_s = wcnt_r + WCNT_ONE;
                end
            end
            default: begin
                state_s = OBJ;
            end
        endcase
    end

    // Core coordinate mux; zeros whenever the run carries no frame.
    always_comb begin
        feed_point_s = point_or_zero(feed_s, rd_point_s);
        X            = feed_point_s.x;
        Y            = feed_point_s.y;
    end

    // FSM state, fence index, live flag and WAIT counter.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= OBJ;
            idx_r   <= 3'd0;
            live_r  <= 1'b0;
            wcnt_r  <= '0;
        end else begin
            state_r <= state_s;
            idx_r   <= idx_s;
            live_r  <= live_s;
            wcnt_r  <= wcnt_s;
        end
    end

    // Read pointer, tag counter, result register and timeout flag.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_slot_r     <= 1'b0;
            rd_tag_r      <= '0;
            res_valid_r   <= 1'b0;
            res_inside_r  <= 1'b0;
            res_tag_r     <= '0;
            err_timeout_r <= 1'b0;
        end else begin
            res_valid_r <= free_s;
            if (free_s) begin
                res_inside_r <= gf_inside;
                res_tag_r    <= rd_tag_r;
                rd_slot_r    <= ~rd_slot_r;
                rd_tag_r     <= rd_tag_r + TAG_ONE;
            end
            if (timeout_s) begin
                err_timeout_r <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_geofence_feeder.sv
// tb_geofence_feeder: directed and randomized stimulus for geofence_feeder.
// A behavioural model (frame queues, run phase counter, ray-casting core)
// predicts X/Y, in_ready, results and error flags for every cycle.
module tb_geofence_feeder;
    import geofence_pkg::*;

    localparam int TIMEOUT = 40;
    localparam int TAG_W   = 8;
    localparam int RUN     = GF_RUN_CYCLES;
    localparam int RUN_TO  = 8 + TIMEOUT;

    typedef logic [FRAME_PTS-1:0][19:0] frame_t;

    logic             clk = 1'b0;
    logic             reset;
    logic [9:0]       X;
    logic [9:0]       Y;
    logic             gf_valid;
    logic             gf_inside;
    logic             res_valid;
    logic             res_inside;
    logic [TAG_W-1:0] res_tag;
    logic             err_seq;
    logic             err_timeout;

    geofence_feeder_if in_if ();

    geofence_feeder #(.TIMEOUT(TIMEOUT), .TAG_W(TAG_W)) dut (
        .clk         (clk),
        .reset       (reset),
        .in_if       (in_if),
        .X           (X),
        .Y           (Y),
        .gf_valid    (gf_valid),
        .gf_inside   (gf_inside),
        .res_valid   (res_valid),
        .res_inside  (res_inside),
        .res_tag     (res_tag),
        .err_seq     (err_seq),
        .err_timeout (err_timeout)
    );

    always #5 clk = ~clk;

    int         n_pass   = 0;
    int         n_checks = 0;
    frame_t     frames_q [$];
    logic [19:0] part_q  [$];
    logic [20:0] src_q   [$];
    int         ph;
    int         run_len;
    bit         live_m;
    frame_t     cur_f;
    frame_t     core_f;
    bit         withhold_next;
    bit         spur_en;
    bit         exp_rv;
    bit         exp_ri;
    logic [7:0] exp_rt;
    logic [7:0] tag_m;
    bit         err_seq_m;
    bit         err_to_m;
    int         vprob;
    int         n_res;
    logic       last_ri;
    logic [7:0] last_rt;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    endtask

    // Ray casting: is point 0 inside the polygon of points 1..6?
    function automatic bit inside_poly(input frame_t f);
        int px, py, xi, yi, xj, yj, j;
        real xc;
        bit odd;
        odd = 1'b0;
        px  = int'(f[0][19:10]);
        py  = int'(f[0][9:0]);
        for (int i = 1; i <= 6; i++) begin
            j  = (i == 1) ? 6 : i - 1;
            xi = int'(f[i][19:10]); yi = int'(f[i][9:0]);
            xj = int'(f[j][19:10]); yj = int'(f[j][9:0]);
            if ((yi > py) != (yj > py)) begin
                xc = real'(xi) + real'(xj - xi) * real'(py - yi) / real'(yj - yi);
                if (real'(px) < xc) odd = ~odd;
            end
        end
        return odd;
    endfunction

    task automatic push_pt(input bit sop, input int x, input int y);
        src_q.push_back({sop, 10'(x), 10'(y)});
    endtask

    task automatic hex_frame(input int ox, input int oy);
        push_pt(1'b1, ox, oy);
        push_pt(1'b0, 10, 0);   push_pt(1'b0, 100, 0); push_pt(1'b0, 120, 50);
        push_pt(1'b0, 100, 100); push_pt(1'b0, 10, 100); push_pt(1'b0, 0, 50);
    endtask

    task automatic rand_frame();
        int dxs [6] = '{2, 1, -1, -2, -1, 1};
        int dys [6] = '{0, 2, 2, 0, -2, -2};
        int cx, cy, r;
        cx = int'($urandom_range(800, 200));
        cy = int'($urandom_range(800, 200));
        push_pt(1'b1, cx + int'($urandom_range(200)) - 100, cy + int'($urandom_range(200)) - 100);
        for (int k = 0; k < 6; k++) begin
            r = int'($urandom_range(120, 40));
            push_pt(1'b0, cx + dxs[k] * r / 2, cy + dys[k] * r / 2);
        end
    endtask

    // Upstream framing rules applied to one accepted point.
    task automatic accept_point(input logic [20:0] w);
        frame_t f;
        if (w[20]) begin
            if (part_q.size() != 0) err_seq_m = 1'b1;
            part_q.delete();
            part_q.push_back(w[19:0]);
        end else if (part_q.size() == 0) begin
            err_seq_m = 1'b1;
        end else begin
            part_q.push_back(w[19:0]);
        end
        if (part_q.size() == FRAME_PTS) begin
            for (int k = 0; k < FRAME_PTS; k++) f[k] = part_q[k];
            frames_q.push_back(f);
            part_q.delete();
        end
    endtask

    // Model update for the clock edge that just happened (inputs still pre-edge).
    task automatic model_edge();
        bit rdy;
        rdy    = frames_q.size() < 2;
        exp_rv = 1'b0;
        if (in_if.in_valid && rdy) begin
            accept_point({in_if.in_sop, in_if.in_x, in_if.in_y});
            if (src_q.size() > 0) src_q.delete(0);
        end
        if (run_len == RUN && ph == RUN - 1 && gf_valid && live_m) begin
            frames_q.delete(0);
            exp_rv = 1'b1;
            exp_ri = inside_poly(cur_f);
            exp_rt = tag_m;
            tag_m  = tag_m + 8'd1;
        end
        if (run_len == RUN_TO && ph == RUN_TO - 1) err_to_m = 1'b1;
        ph = (ph + 1 == run_len) ? 0 : ph + 1;
    endtask

    task automatic check_cycle();
        int ex, ey;
        if (ph == 0) begin
            live_m = frames_q.size() > 0;
            if (live_m) cur_f = frames_q[0];
            run_len       = withhold_next ? RUN_TO : RUN;
            withhold_next = 1'b0;
        end
        ex = 0;
        ey = 0;
        if (ph <= 6 && live_m) begin
            ex = int'(cur_f[ph][19:10]);
            ey = int'(cur_f[ph][9:0]);
        end
        chk("X", 32'(X), 32'(ex));
        chk("Y", 32'(Y), 32'(ey));
        chk("in_ready", 32'(in_if.in_ready), 32'(frames_q.size() < 2));
        chk("res_valid", 32'(res_valid), 32'(exp_rv));
        chk("res_inside", 32'(res_inside), 32'(exp_ri));
        chk("res_tag", 32'(res_tag), 32'(exp_rt));
        chk("err_seq", 32'(err_seq), 32'(err_seq_m));
        chk("err_timeout", 32'(err_timeout), 32'(err_to_m));
        if (ph <= 6) core_f[ph] = {X, Y};
        if (res_valid === 1'b1) begin
            n_res++;
            last_ri = res_inside;
            last_rt = res_tag;
        end
    endtask

    // Core result pulse plus upstream point source for the current cycle.
    task automatic drive();
        gf_valid  = (ph == RUN - 1) && (run_len == RUN);
        gf_inside = gf_valid ? inside_poly(core_f) : 1'b0;
        if (!gf_valid && spur_en && ph <= 7 && $urandom_range(7) == 0) begin
            gf_valid  = 1'b1;
            gf_inside = 1'($urandom_range(1));
        end
        if (src_q.size() > 0 && int'($urandom_range(99)) < vprob) begin
            in_if.in_valid = 1'b1;
            {in_if.in_sop, in_if.in_x, in_if.in_y} = src_q[0];
        end else begin
            in_if.in_valid = 1'b0;
            in_if.in_sop   = 1'($urandom_range(1));
            in_if.in_x     = 10'($urandom_range(1023));
            in_if.in_y     = 10'($urandom_range(1023));
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        check_cycle();
        drive();
    endtask

    task automatic do_reset();
        in_if.in_valid = 1'b0;
        gf_valid       = 1'b0;
        gf_inside      = 1'b0;
        reset          = 1'b1;
        #1;
        chk("rst_in_ready", 32'(in_if.in_ready), 32'd1);
        chk("rst_X", 32'(X), 32'd0);
        chk("rst_Y", 32'(Y), 32'd0);
        chk("rst_res_valid", 32'(res_valid), 32'd0);
        chk("rst_res_tag", 32'(res_tag), 32'd0);
        chk("rst_errs", 32'({err_seq, err_timeout}), 32'd0);
        frames_q.delete(); part_q.delete(); src_q.delete();
        ph = 0; run_len = RUN; live_m = 1'b0; withhold_next = 1'b0;
        exp_rv = 1'b0; exp_ri = 1'b0; exp_rt = 8'd0; tag_m = 8'd0;
        err_seq_m = 1'b0; err_to_m = 1'b0; core_f = '0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        check_cycle();
        drive();
    endtask

    task automatic drain(input int bound);
        int n;
        n = 0;
        while ((src_q.size() > 0 || frames_q.size() > 0) && n < bound) begin
            tick();
            n++;
        end
        chk("drain_left", 32'(src_q.size() + frames_q.size()), 32'd0);
        repeat (3) tick();
    endtask

    initial begin
        int n, r0;
        spur_en = 1'b0;
        vprob   = 100;
        n_res   = 0;
        do_reset();

        // Idle: dummy runs only.
        repeat (100) tick();
        chk("t1_no_res", 32'(n_res), 32'd0);

        // Object inside then outside the same hexagon.
        hex_frame(50, 50);
        drain(200);
        chk("t2_inside", 32'(last_ri), 32'd1);
        chk("t2_tag0", 32'(last_rt), 32'd0);
        hex_frame(500, 500);
        drain(200);
        chk("t2_outside", 32'(last_ri), 32'd0);
        chk("t2_tag1", 32'(last_rt), 32'd1);

        // Three frames back to back.
        do_reset();
        r0 = n_res;
        repeat (3) rand_frame();
        drain(400);
        chk("t3_count", 32'(n_res - r0), 32'd3);
        chk("t3_last_tag", 32'(last_rt), 32'd2);

        // Orphan point, then sop at index 3, then a good frame.
        push_pt(1'b0, 1, 1);
        push_pt(1'b1, 300, 300); push_pt(1'b0, 310, 300); push_pt(1'b0, 300, 310);
        rand_frame();
        drain(200);
        chk("t4_err_seq", 32'(err_seq), 32'd1);
        chk("t4_tag", 32'(last_rt), 32'd3);

        // Reset while a live frame is on the fence vertices.
        rand_frame();
        n = 0;
        while (!(ph == 4 && live_m) && n < 200) begin
            tick();
            n++;
        end
        chk("t5_reached", 32'(ph), 32'd4);
        r0 = n_res;
        do_reset();
        repeat (60) tick();
        chk("t5_no_res", 32'(n_res - r0), 32'd0);

        // Core withholds its result for one run.
        rand_frame();
        n = 0;
        while (!(ph == RUN - 1 && frames_q.size() > 0) && n < 200) begin
            tick();
            n++;
        end
        withhold_next = 1'b1;
        r0 = n_res;
        repeat (RUN_TO + RUN + 4) tick();
        chk("t6_err_timeout", 32'(err_timeout), 32'd1);
        chk("t6_one_res", 32'(n_res - r0), 32'd1);
        chk("t6_tag", 32'(last_rt), 32'd0);

        // Random traffic with idle gaps and stray core pulses.
        spur_en = 1'b1;
        vprob   = 60;
        repeat (8) rand_frame();
        drain(1500);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
